// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: reads a raw message from synchronous memory and streams it
// with SHA-256 padding as indexed 32-bit words over a valid/ready interface.
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] input_addr,
    input  logic [31:0] memory_read_data,
    output logic        memory_clk,
    output logic [15:0] memory_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_word_idx,
    output logic [7:0]  out_block_idx,
    output logic        out_last_block,
    output logic        done
);
    localparam int          NUM_BLOCKS = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam int          TOTAL      = 16 * NUM_BLOCKS;
    localparam logic [63:0] LEN        = 64'(NUM_OF_WORDS) * 64'd32;
    localparam logic [15:0] N16        = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LAST       = 16'(TOTAL - 1);
    localparam logic [7:0]  LAST_BLK   = 8'(NUM_BLOCKS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, PAD} state_t;

    state_t      state, state_nxt;
    logic [15:0] base, base_nxt, k, k_nxt, k_inc, addr_nxt, idx;
    logic [31:0] data_nxt;
    logic        valid_nxt, load, xfer;

    function automatic logic [31:0] pad_of(input logic [15:0] j);
        return j == N16 ? 32'h8000_0000 : j == LAST - 16'd1 ? LEN[63:32] : j == LAST ? LEN[31:0] : 32'h0;
    endfunction

    assign memory_clk = clk;
    assign done       = state == IDLE;
    assign xfer       = out_valid && out_ready;
    assign k_inc      = k + 16'd1;

    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        k_nxt     = k;
        addr_nxt  = memory_addr;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        load      = 1'b0;
        idx       = k;
        case (state)
            IDLE: if (start) begin
                base_nxt  = input_addr;
                k_nxt     = '0;
                addr_nxt  = input_addr;
                state_nxt = FETCH;
            end
            FETCH: state_nxt = WAIT;
            WAIT: begin
                data_nxt  = memory_read_data;
                valid_nxt = 1'b1;
                load      = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: if (xfer) begin
                k_nxt = k_inc;
                if (k_inc < N16) begin
                    addr_nxt  = base + k_inc;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else begin
                    // first pad word is presented on the same edge as the last message transfer
                    data_nxt  = pad_of(k_inc);
                    load      = 1'b1;
                    idx       = k_inc;
                    state_nxt = PAD;
                end
            end
            PAD: if (xfer) begin
                if (k == LAST) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    k_nxt    = k_inc;
                    data_nxt = pad_of(k_inc);
                    load     = 1'b1;
                    idx      = k_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            base           <= '0;
            k              <= '0;
            memory_addr    <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_word_idx   <= '0;
            out_block_idx  <= '0;
            out_last_block <= 1'b0;
        end else begin
            state       <= state_nxt;
            base        <= base_nxt;
            k           <= k_nxt;
            memory_addr <= addr_nxt;
            out_valid   <= valid_nxt;
            out_data    <= data_nxt;
            if (load) begin
                out_word_idx   <= idx[3:0];
                out_block_idx  <= 8'(idx >> 4);
                out_last_block <= 8'(idx >> 4) == LAST_BLK;
            end
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: three padder instances (40, 13, 14 words) checked against
// a word-level padding model over a shared synchronous memory.
module tb_sha256_msg_padder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic [15:0] input_addr = '0;
    logic        out_ready = 1'b0;
    logic [31:0] mem [65536];
    logic [31:0] rd [3];
    logic [15:0] ma [3];
    logic [31:0] od [3];
    logic [3:0]  wi [3];
    logic [7:0]  bi [3];
    logic        mc [3], ov [3], lb [3], dn [3];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int i = 0; i < 3; i++) rd[i] <= mem[ma[i]];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha256_msg_padder #(.NUM_OF_WORDS(g == 0 ? 40 : g == 1 ? 13 : 14)) dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .input_addr(input_addr),
            .memory_read_data(rd[g]), .memory_clk(mc[g]), .memory_addr(ma[g]),
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
            .out_word_idx(wi[g]), .out_block_idx(bi[g]), .out_last_block(lb[g]), .done(dn[g]));
    end

    function automatic int nw(input int s);
        return s == 0 ? 40 : s == 1 ? 13 : 14;
    endfunction

    function automatic int nblk(input int n);
        return (n + 2) / 16 + 1;
    endfunction

    function automatic logic [31:0] exp_word(input int n, input logic [15:0] b, input int k);
        logic [63:0] len;
        logic [15:0] a;
        int total;
        len   = 64'(n) * 64'd32;
        total = 16 * nblk(n);
        a     = b + 16'(k);
        if (k < n) return mem[a];
        if (k == n) return 32'h8000_0000;
        if (k == total - 2) return len[63:32];
        if (k == total - 1) return len[31:0];
        return 32'h0;
    endfunction

    task automatic fill(input int n, input logic [15:0] b, input bit count_up);
        for (int k = 0; k < n; k++) mem[16'(b + 16'(k))] = count_up ? 32'(k + 1) : $urandom;
    endtask

    task automatic run_stream(input int s, input logic [15:0] b, input bit rnd,
                              input int stall_at, input int start_at, input int rst_at);
        int n, total, got, cyc, stall, expc;
        bit pv, pr, stalled, aborted;
        logic [31:0] pd;
        logic [3:0]  pwi;
        logic [7:0]  pbi;
        n = nw(s); total = 16 * nblk(n);
        got = 0; cyc = 0; stall = 0; pv = 0; pr = 0; stalled = 0; aborted = 0;
        pd = '0; pwi = '0; pbi = '0;
        @(negedge clk);
        input_addr = b;
        start[s] = 1'b1;
        while (got < total && cyc < 3000 && !aborted) begin
            @(negedge clk);
            start = '0;
            cyc++;
            if (pv && !pr) begin
                tests++;
                if (ov[s] !== 1'b1 || od[s] !== pd || wi[s] !== pwi || bi[s] !== pbi) begin
                    fails++;
                    $display("FAIL hold n=%0d word=%0d: valid=%b data=%h idx=%0d/%0d, required valid=1 data=%h idx=%0d/%0d",
                             n, got, ov[s], od[s], bi[s], wi[s], pd, pbi, pwi);
                end
            end
            if (ov[s] && got == rst_at) begin
                rst_n = 1'b0;
                #1;
                tests++;
                if (ov[s] !== 1'b0 || dn[s] !== 1'b1) begin
                    fails++;
                    $display("FAIL async_reset: valid=%b done=%b, required valid=0 done=1", ov[s], dn[s]);
                end
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
            end else begin
                if (ov[s] && got == stall_at && !stalled) begin
                    stalled = 1;
                    stall = 10;
                end
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ov[s] && out_ready) begin
                    tests++;
                    if (od[s] !== exp_word(n, b, got) || wi[s] !== 4'(got % 16) || bi[s] !== 8'(got / 16)
                        || lb[s] !== (got / 16 == nblk(n) - 1)) begin
                        fails++;
                        $display("FAIL word n=%0d k=%0d: data=%h blk=%0d idx=%0d last=%b, required data=%h blk=%0d idx=%0d last=%b",
                                 n, got, od[s], bi[s], wi[s], lb[s], exp_word(n, b, got), got / 16, got % 16,
                                 got / 16 == nblk(n) - 1);
                    end
                    if (got < n) begin
                        tests++;
                        if (ma[s] !== 16'(b + 16'(got))) begin
                            fails++;
                            $display("FAIL mem_addr n=%0d k=%0d: got %h, required %h", n, got, ma[s], 16'(b + 16'(got)));
                        end
                    end
                    if (!rnd && stall_at < 0) begin
                        expc = got < n ? 3 * (got + 1) : 3 * n + (got - n + 1);
                        tests++;
                        if (cyc != expc) begin
                            fails++;
                            $display("FAIL timing n=%0d k=%0d: cycle %0d, required %0d", n, got, cyc, expc);
                        end
                    end
                    if (got == start_at) start[s] = 1'b1;
                    got++;
                end
                pv = ov[s]; pr = out_ready; pd = od[s]; pwi = wi[s]; pbi = bi[s];
            end
        end
        if (!aborted) begin
            tests++;
            if (got != total) begin
                fails++;
                $display("FAIL timeout n=%0d: %0d words transferred, required %0d", n, got, total);
            end
            @(negedge clk);
            tests++;
            if (dn[s] !== 1'b1 || ov[s] !== 1'b0) begin
                fails++;
                $display("FAIL end_idle n=%0d: done=%b valid=%b, required done=1 valid=0", n, dn[s], ov[s]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (ov[0] !== 1'b0 || od[0] !== '0 || wi[0] !== '0 || bi[0] !== '0 || lb[0] !== 1'b0
            || ma[0] !== '0 || dn[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: valid=%b data=%h idx=%0d/%0d last=%b addr=%h done=%b, required all 0, done=1",
                     ov[0], od[0], bi[0], wi[0], lb[0], ma[0], dn[0]);
        end
        tests++;
        if (mc[0] !== clk) begin
            fails++;
            $display("FAIL memory_clk: got %b, required %b", mc[0], clk);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full40();
        fill(40, 16'h0100, 1);
        run_stream(0, 16'h0100, 0, -1, -1, -1);
    endtask

    task automatic test_n13();
        fill(13, 16'h2000, 0);
        run_stream(1, 16'h2000, 0, -1, -1, -1);
    endtask

    task automatic test_n14();
        fill(14, 16'h3000, 0);
        run_stream(2, 16'h3000, 0, -1, -1, -1);
    endtask

    task automatic test_backpressure();
        fill(40, 16'h0100, 1);
        run_stream(0, 16'h0100, 1, 39, -1, -1);
    endtask

    task automatic test_midstream();
        fill(40, 16'h4000, 0);
        run_stream(0, 16'h4000, 0, -1, 20, 25);
        run_stream(0, 16'h4000, 0, -1, -1, -1);
    endtask

    task automatic test_addr_wrap();
        fill(40, 16'hFFF0, 0);
        run_stream(0, 16'hFFF0, 1, -1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_full40();
        test_n13();
        test_n14();
        test_backpressure();
        test_midstream();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
